// File: rtl/io_map_pkg.sv
// ============================================================================
//  Module      : io_map_pkg
//  Description : IO address map, data widths and address decode helper shared
//                by the MMIO responder and the control unit's IO decode.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package io_map_pkg;

   localparam int IO_DATA_W = 32;
   localparam int IO_ADDR_W = 32;

   localparam logic [IO_ADDR_W-1:0] IO_BASE  = 32'hFFFF_FC00;
   localparam logic [IO_ADDR_W-1:0] IO_LED   = 32'hFFFF_FC60;
   localparam logic [IO_ADDR_W-1:0] IO_SW    = 32'hFFFF_FC70;
   localparam logic [IO_ADDR_W-1:0] IO_BTN   = 32'hFFFF_FC74;
   localparam logic [IO_ADDR_W-1:0] IO_SEG   = 32'hFFFF_FC80;
   localparam logic [IO_ADDR_W-1:0] IO_TIMER = 32'hFFFF_FC90;

   typedef enum logic [2:0] {
      SEL_NONE  = 3'd0,
      SEL_LED   = 3'd1,
      SEL_SW    = 3'd2,
      SEL_BTN   = 3'd3,
      SEL_SEG   = 3'd4,
      SEL_TIMER = 3'd5
   } io_sel_e;

   // Full-address match: misaligned addresses never hit a register.
   function automatic io_sel_e io_decode(input logic [IO_ADDR_W-1:0] addr);
      if (addr[IO_ADDR_W-1:10] != IO_BASE[IO_ADDR_W-1:10]) return SEL_NONE;
      case (addr)
         IO_LED:   return SEL_LED;
         IO_SW:    return SEL_SW;
         IO_BTN:   return SEL_BTN;
         IO_SEG:   return SEL_SEG;
         IO_TIMER: return SEL_TIMER;
         default:  return SEL_NONE;
      endcase
   endfunction

endpackage

`default_nettype wire

// File: rtl/io_debounce.sv
// ============================================================================
//  Module      : io_debounce
//  Description : Two-flop synchronizer followed by a whole-bus debounce
//                counter; dout follows din once it has been stable long enough.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module io_debounce #(
   parameter int W         = 16,
   parameter int DB_CYCLES = 1000000
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout
);

   localparam int              CNT_W   = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

   logic [W-1:0]     sync1_q, sync1_d;
   logic [W-1:0]     sync2_q, sync2_d;
   logic [W-1:0]     cand_q,  cand_d;
   logic [W-1:0]     out_q,   out_d;
   logic [CNT_W-1:0] cnt_q,   cnt_d;

   always_comb begin
      sync1_d = din;
      sync2_d = sync1_q;
      cand_d  = cand_q;
      cnt_d   = cnt_q;
      out_d   = out_q;
      // Any change restarts the stability window; a full window holds the count.
      if (sync2_q != cand_q) begin
         cand_d = sync2_q;
         cnt_d  = '0;
      end else if (cnt_q == CNT_MAX) begin
         out_d = cand_q;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q <= '0;
         sync2_q <= '0;
         cand_q  <= '0;
         cnt_q   <= '0;
         out_q   <= '0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         cand_q  <= cand_d;
         cnt_q   <= cnt_d;
         out_q   <= out_d;
      end
   end

   assign dout = out_q;

endmodule

`default_nettype wire

// File: rtl/io_mmio_responder.sv
// ============================================================================
//  Module      : io_mmio_responder
//  Description : IORead/IOWrite responder holding LED, seven-segment, switch,
//                button and free-running timer registers.
//                Optional macro IO_BTN_EDGE_EN: BTN reads return sticky
//                clear-on-read rising-edge flags instead of the level.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module io_mmio_responder
   import io_map_pkg::*;
#(
   parameter int SW_W      = 16,
   parameter int LED_W     = 16,
   parameter int BTN_W     = 5,
   parameter int DB_CYCLES = 1000000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             io_read,
   input  logic             io_write,
   input  logic [31:0]      addr,
   input  logic [31:0]      wdata,
   output logic [31:0]      rdata,
   output logic             rvalid,
   output logic             addr_err,
   input  logic [SW_W-1:0]  sw,
   input  logic [BTN_W-1:0] btn,
   output logic [LED_W-1:0] led,
   output logic [31:0]      seg_value
);

   logic [SW_W-1:0]  sw_db;
   logic [BTN_W-1:0] btn_db;
   logic [BTN_W-1:0] btn_rd_val;

   io_debounce #(.W(SW_W), .DB_CYCLES(DB_CYCLES)) u_sw_db (
      .clk  (clk),
      .rst  (rst),
      .din  (sw),
      .dout (sw_db)
   );

   io_debounce #(.W(BTN_W), .DB_CYCLES(DB_CYCLES)) u_btn_db (
      .clk  (clk),
      .rst  (rst),
      .din  (btn),
      .dout (btn_db)
   );

   io_sel_e              sel;
   logic                 rd_en;
   logic                 wr_ok;
   logic                 rd_ok;

   logic [LED_W-1:0]     led_q,    led_d;
   logic [IO_DATA_W-1:0] seg_q,    seg_d;
   logic [IO_DATA_W-1:0] timer_q,  timer_d;
   logic [IO_DATA_W-1:0] rdata_q,  rdata_d;
   logic                 rvalid_q, rvalid_d;
   logic                 err_q,    err_d;

   always_comb begin
      sel   = io_decode(addr);
      // A simultaneous read and write is treated as a write only.
      rd_en = io_read & ~io_write;
      wr_ok = (sel == SEL_LED) || (sel == SEL_SEG) || (sel == SEL_TIMER);
      rd_ok = (sel != SEL_NONE);
   end

`ifdef IO_BTN_EDGE_EN
   logic [BTN_W-1:0] btn_prev_q, btn_prev_d;
   logic [BTN_W-1:0] btn_flag_q, btn_flag_d;
   logic [BTN_W-1:0] btn_clr;

   always_comb begin
      btn_prev_d = btn_db;
      btn_clr    = (rd_en && sel == SEL_BTN) ? btn_flag_q : '0;
      // Clear only what was returned; an edge landing in the read cycle survives.
      btn_flag_d = (btn_flag_q & ~btn_clr) | (btn_db & ~btn_prev_q);
      btn_rd_val = btn_flag_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         btn_prev_q <= '0;
         btn_flag_q <= '0;
      end else begin
         btn_prev_q <= btn_prev_d;
         btn_flag_q <= btn_flag_d;
      end
   end
`else
   always_comb begin
      btn_rd_val = btn_db;
   end
`endif

   always_comb begin
      led_d    = led_q;
      seg_d    = seg_q;
      timer_d  = timer_q + 1'b1;
      rdata_d  = rdata_q;
      rvalid_d = 1'b0;
      err_d    = (io_read & io_write) | (io_write & ~wr_ok) | (rd_en & ~rd_ok);

      if (io_write) begin
         case (sel)
            SEL_LED:   led_d   = wdata[LED_W-1:0];
            SEL_SEG:   seg_d   = wdata;
            SEL_TIMER: timer_d = wdata;
            default:   ;
         endcase
      end

      if (rd_en) begin
         rvalid_d = 1'b1;
         case (sel)
            SEL_LED:   rdata_d = IO_DATA_W'(led_q);
            SEL_SW:    rdata_d = IO_DATA_W'(sw_db);
            SEL_BTN:   rdata_d = IO_DATA_W'(btn_rd_val);
            SEL_SEG:   rdata_d = seg_q;
            SEL_TIMER: rdata_d = timer_q;
            default:   rdata_d = '0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         led_q    <= '0;
         seg_q    <= '0;
         timer_q  <= '0;
         rdata_q  <= '0;
         rvalid_q <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         led_q    <= led_d;
         seg_q    <= seg_d;
         timer_q  <= timer_d;
         rdata_q  <= rdata_d;
         rvalid_q <= rvalid_d;
         err_q    <= err_d;
      end
   end

   assign led       = led_q;
   assign seg_value = seg_q;
   assign rdata     = rdata_q;
   assign rvalid    = rvalid_q;
   assign addr_err  = err_q;

endmodule

`default_nettype wire

// File: tb/tb_io_mmio_responder.sv
// ============================================================================
//  Module      : tb_io_mmio_responder
//  Description : Self-checking bench for io_mmio_responder (DB_CYCLES=4);
//                expectations for BTN reads follow IO_BTN_EDGE_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_io_mmio_responder;

   localparam logic [31:0] A_LED   = 32'hFFFF_FC60;
   localparam logic [31:0] A_SW    = 32'hFFFF_FC70;
   localparam logic [31:0] A_BTN   = 32'hFFFF_FC74;
   localparam logic [31:0] A_SEG   = 32'hFFFF_FC80;
   localparam logic [31:0] A_TIMER = 32'hFFFF_FC90;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        io_read = 1'b0;
   logic        io_write = 1'b0;
   logic [31:0] addr = '0;
   logic [31:0] wdata = '0;
   logic [31:0] rdata;
   logic        rvalid;
   logic        addr_err;
   logic [15:0] sw = '0;
   logic [4:0]  btn = '0;
   logic [15:0] led;
   logic [31:0] seg_value;

   int n_checks = 0;
   int n_fail   = 0;
   logic [31:0] rd_q[$];

   typedef struct {
      logic        rd;
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        exp_rv;
      logic [31:0] exp_rdata;
      logic        exp_err;
      logic [15:0] exp_led;
      logic [31:0] exp_seg;
   } vec_t;

   vec_t vecs[15];

   io_mmio_responder #(
      .SW_W(16), .LED_W(16), .BTN_W(5), .DB_CYCLES(4)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .io_read   (io_read),
      .io_write  (io_write),
      .addr      (addr),
      .wdata     (wdata),
      .rdata     (rdata),
      .rvalid    (rvalid),
      .addr_err  (addr_err),
      .sw        (sw),
      .btn       (btn),
      .led       (led),
      .seg_value (seg_value)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // One bus cycle: read expectations go to the scoreboard and are matched
   // against whatever response the DUT returns after the edge.
   task automatic access(input logic rd, input logic wr, input logic [31:0] a,
                         input logic [31:0] wd, input logic exp_rv,
                         input logic [31:0] exp_rd, input logic exp_err);
      io_read  = rd;
      io_write = wr;
      addr     = a;
      wdata    = wd;
      if (exp_rv) rd_q.push_back(exp_rd);
      @(posedge clk);
      #1;
      io_read  = 1'b0;
      io_write = 1'b0;
      check("rvalid", {31'b0, rvalid}, {31'b0, exp_rv});
      check("addr_err", {31'b0, addr_err}, {31'b0, exp_err});
      if (rvalid) begin
         if (rd_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL rdata: unexpected response %h, none expected", rdata);
         end else begin
            check("rdata", rdata, rd_q.pop_front());
         end
      end
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) access(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] btn_after_release;

      vecs[0]  = '{1'b0, 1'b1, A_LED,          32'h0001_A5A5, 1'b0, 32'h0,          1'b0, 16'hA5A5, 32'h0};
      vecs[1]  = '{1'b1, 1'b0, A_LED,          32'h0,         1'b1, 32'h0000_A5A5,  1'b0, 16'hA5A5, 32'h0};
      vecs[2]  = '{1'b0, 1'b1, A_SEG,          32'h1234_5678, 1'b0, 32'h0,          1'b0, 16'hA5A5, 32'h1234_5678};
      vecs[3]  = '{1'b1, 1'b0, A_SEG,          32'h0,         1'b1, 32'h1234_5678,  1'b0, 16'hA5A5, 32'h1234_5678};
      vecs[4]  = '{1'b1, 1'b0, A_SW,           32'h0,         1'b1, 32'h0,          1'b0, 16'hA5A5, 32'h1234_5678};
      vecs[5]  = '{1'b0, 1'b1, A_SW,           32'hFFFF_FFFF, 1'b0, 32'h0,          1'b1, 16'hA5A5, 32'h1234_5678};
      vecs[6]  = '{1'b1, 1'b0, 32'hFFFF_FC64,  32'h0,         1'b1, 32'h0,          1'b1, 16'hA5A5, 32'h1234_5678};
      vecs[7]  = '{1'b1, 1'b0, 32'hFFFF_FC62,  32'h0,         1'b1, 32'h0,          1'b1, 16'hA5A5, 32'h1234_5678};
      vecs[8]  = '{1'b0, 1'b1, 32'hFFFF_FC00,  32'h5555_5555, 1'b0, 32'h0,          1'b1, 16'hA5A5, 32'h1234_5678};
      vecs[9]  = '{1'b1, 1'b0, A_LED,          32'h0,         1'b1, 32'h0000_A5A5,  1'b0, 16'hA5A5, 32'h1234_5678};
      vecs[10] = '{1'b0, 1'b1, A_LED,          32'hFFFF_0000, 1'b0, 32'h0,          1'b0, 16'h0000, 32'h1234_5678};
      vecs[11] = '{1'b1, 1'b0, A_LED,          32'h0,         1'b1, 32'h0,          1'b0, 16'h0000, 32'h1234_5678};
      vecs[12] = '{1'b0, 1'b1, A_LED,          32'h0000_BEEF, 1'b0, 32'h0,          1'b0, 16'hBEEF, 32'h1234_5678};
      vecs[13] = '{1'b1, 1'b0, A_LED,          32'h0,         1'b1, 32'h0000_BEEF,  1'b0, 16'hBEEF, 32'h1234_5678};
      vecs[14] = '{1'b0, 1'b0, 32'h0,          32'h0,         1'b0, 32'h0,          1'b0, 16'hBEEF, 32'h1234_5678};

      // Reset state
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("reset_led", {16'h0, led}, 32'h0);
      check("reset_seg", seg_value, 32'h0);
      check("reset_rdata", rdata, 32'h0);
      check("reset_rvalid", {31'b0, rvalid}, 32'h0);
      check("reset_addr_err", {31'b0, addr_err}, 32'h0);
      rst = 1'b0;
      access(1'b1, 1'b0, A_TIMER, 32'h0, 1'b1, 32'h0, 1'b0);

      for (int i = 0; i < 15; i++) begin
         access(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata,
                vecs[i].exp_rv, vecs[i].exp_rdata, vecs[i].exp_err);
         check("led", {16'h0, led}, {16'h0, vecs[i].exp_led});
         check("seg_value", seg_value, vecs[i].exp_seg);
      end
      check("rdata_hold", rdata, 32'h0000_BEEF);

      // Read and write together: write happens, no response, error flagged
      access(1'b1, 1'b1, A_SEG, 32'hCAFE_F00D, 1'b0, 32'h0, 1'b1);
      check("seg_conflict", seg_value, 32'hCAFE_F00D);
      access(1'b1, 1'b0, A_SEG, 32'h0, 1'b1, 32'hCAFE_F00D, 1'b0);

      // Timer load wins over increment, then counts and wraps
      access(1'b0, 1'b1, A_TIMER, 32'hFFFF_FFFE, 1'b0, 32'h0, 1'b0);
      access(1'b1, 1'b0, A_TIMER, 32'h0, 1'b1, 32'hFFFF_FFFE, 1'b0);
      access(1'b1, 1'b0, A_TIMER, 32'h0, 1'b1, 32'hFFFF_FFFF, 1'b0);
      access(1'b1, 1'b0, A_TIMER, 32'h0, 1'b1, 32'h0000_0000, 1'b0);

      // Switch glitch shorter than the debounce window is ignored
      sw = 16'h00F0;
      idle(2);
      sw = 16'h0000;
      idle(8);
      access(1'b1, 1'b0, A_SW, 32'h0, 1'b1, 32'h0, 1'b0);

      // Stable switch change appears only after sync + debounce latency
      sw = 16'h00F0;
      idle(3);
      access(1'b1, 1'b0, A_SW, 32'h0, 1'b1, 32'h0, 1'b0);
      idle(8);
      access(1'b1, 1'b0, A_SW, 32'h0, 1'b1, 32'h0000_00F0, 1'b0);

      // Button press and release
      btn = 5'b00100;
      idle(10);
`ifndef IO_BTN_EDGE_EN
      access(1'b1, 1'b0, A_BTN, 32'h0, 1'b1, 32'h0000_0004, 1'b0);
`endif
      btn = 5'b00000;
      idle(10);
`ifdef IO_BTN_EDGE_EN
      btn_after_release = 32'h0000_0004;
`else
      btn_after_release = 32'h0000_0000;
`endif
      access(1'b1, 1'b0, A_BTN, 32'h0, 1'b1, btn_after_release, 1'b0);
      access(1'b1, 1'b0, A_BTN, 32'h0, 1'b1, 32'h0, 1'b0);

      // Access issued during reset produces no response
      access(1'b0, 1'b1, A_LED, 32'h0000_1234, 1'b0, 32'h0, 1'b0);
      check("led_pre_reset", {16'h0, led}, 32'h0000_1234);
      rst     = 1'b1;
      io_read = 1'b1;
      addr    = A_LED;
      @(posedge clk);
      #1;
      check("rst_rvalid", {31'b0, rvalid}, 32'h0);
      check("rst_led", {16'h0, led}, 32'h0);
      rst     = 1'b0;
      io_read = 1'b0;
      @(posedge clk);
      #1;
      check("post_rst_rvalid", {31'b0, rvalid}, 32'h0);
      check("post_rst_addr_err", {31'b0, addr_err}, 32'h0);
      check("scoreboard_empty", rd_q.size(), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
